// File: rtl/strm_operand_player.sv
// Operand playback engine: replays per-lane A/B operand memories into LANES
// independent valid/ready streams and tracks the results returned per lane.
module strm_operand_player #(
  parameter int LANES  = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                      clk,
  input  logic                      reset_poweron,
  input  logic                      ld_valid,
  input  logic [LW-1:0]             ld_lane,
  input  logic                      ld_stream,
  input  logic [AW-1:0]             ld_addr,
  input  logic [DATA_W-1:0]         ld_data,
  input  logic                      start,
  input  logic [AW:0]               num_ops,
  input  logic [1:0]                op_mode,
  input  logic [2:0]                rnd_mode,
  output logic [LANES-1:0]          op_valid,
  output logic [LANES*DATA_W-1:0]   op_a,
  output logic [LANES*DATA_W-1:0]   op_b,
  output logic [LANES-1:0]          op_sub,
  output logic [2:0]                op_rnd,
  input  logic [LANES-1:0]          op_ready,
  input  logic [LANES-1:0]          res_valid,
  input  logic [LANES*DATA_W-1:0]   res_data,
  output logic                      busy,
  output logic                      done,
  output logic [LANES*DATA_W-1:0]   res_last,
  output logic                      res_err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  function automatic logic [AW:0] clamp_ops(input logic [AW:0] n);
    return (n > DEPTH_C) ? DEPTH_C : n;
  endfunction

  state_t            state;
  logic [AW:0]       nops_q;
  logic [1:0]        mode_q;
  logic [AW:0]       issue_cnt [LANES];
  logic [AW:0]       res_cnt   [LANES];
  logic [AW:0]       issue_nxt [LANES];
  logic [LANES-1:0]  fire;
  logic              all_issued;
  logic              all_done;
  logic              ld_open;

  // Operand storage has no reset so loaded operands survive an abort.
  logic [DATA_W-1:0] mem [LANES][2][DEPTH];

  assign ld_open = (state == IDLE) || (state == DONE);

  always_ff @(posedge clk) begin
    if (ld_valid && ld_open)
      mem[ld_lane][ld_stream][ld_addr] <= ld_data;
  end

  // Operands are read straight from the lane pointer, so they stay put under stall.
  always_comb begin
    op_valid   = '0;
    op_sub     = '0;
    op_a       = '0;
    op_b       = '0;
    fire       = '0;
    all_issued = 1'b1;
    all_done   = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      issue_nxt[i] = issue_cnt[i];
      op_valid[i]  = (state == RUN) && (issue_cnt[i] < nops_q);
      fire[i]      = op_valid[i] & op_ready[i];
      issue_nxt[i] = issue_cnt[i] + {{AW{1'b0}}, fire[i]};
      if (op_valid[i]) begin
        op_a[i*DATA_W +: DATA_W] = mem[i][0][issue_cnt[i][AW-1:0]];
        op_b[i*DATA_W +: DATA_W] = mem[i][1][issue_cnt[i][AW-1:0]];
        op_sub[i] = (mode_q == 2'b01) | ((mode_q == 2'b10) & issue_cnt[i][0]);
      end
      if (issue_cnt[i] != nops_q) all_issued = 1'b0;
      if (res_cnt[i] != nops_q)   all_done   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      res_err  <= 1'b0;
      nops_q   <= '0;
      mode_q   <= '0;
      op_rnd   <= '0;
      res_last <= '0;
      for (int i = 0; i < LANES; i++) begin
        issue_cnt[i] <= '0;
        res_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        issue_cnt[i] <= issue_nxt[i];
        // Compare against the post-increment count so a same-cycle echo is legal.
        if ((state != IDLE) && res_valid[i]) begin
          if (res_cnt[i] < issue_nxt[i]) begin
            res_last[i*DATA_W +: DATA_W] <= res_data[i*DATA_W +: DATA_W];
            res_cnt[i] <= res_cnt[i] + 1'b1;
          end else begin
            res_err <= 1'b1;
          end
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            nops_q  <= clamp_ops(num_ops);
            mode_q  <= op_mode;
            op_rnd  <= rnd_mode;
            res_err <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
              issue_cnt[i] <= '0;
              res_cnt[i]   <= '0;
            end
            if (num_ops == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (all_issued) state <= DRAIN;
        end
        DRAIN: begin
          if (all_done) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_strm_operand_player.sv
// Bench for strm_operand_player: table of directed playbacks, hand sequences for
// stall/abort/late-result cases, and randomized runs against a counting model.
module tb_strm_operand_player;
  localparam int LANES  = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int AW     = 6;
  localparam int LW     = 2;

  logic                    clk = 1'b0;
  logic                    reset_poweron;
  logic                    ld_valid;
  logic [LW-1:0]           ld_lane;
  logic                    ld_stream;
  logic [AW-1:0]           ld_addr;
  logic [DATA_W-1:0]       ld_data;
  logic                    start;
  logic [AW:0]             num_ops;
  logic [1:0]              op_mode;
  logic [2:0]              rnd_mode;
  logic [LANES-1:0]        op_valid;
  logic [LANES*DATA_W-1:0] op_a;
  logic [LANES*DATA_W-1:0] op_b;
  logic [LANES-1:0]        op_sub;
  logic [2:0]              op_rnd;
  logic [LANES-1:0]        op_ready;
  logic [LANES-1:0]        res_valid;
  logic [LANES*DATA_W-1:0] res_data;
  logic                    busy;
  logic                    done;
  logic [LANES*DATA_W-1:0] res_last;
  logic                    res_err;

  always #5 clk = ~clk;

  strm_operand_player #(.LANES(LANES), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_poweron(reset_poweron),
    .ld_valid(ld_valid), .ld_lane(ld_lane), .ld_stream(ld_stream),
    .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .num_ops(num_ops), .op_mode(op_mode), .rnd_mode(rnd_mode),
    .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
    .op_rnd(op_rnd), .op_ready(op_ready),
    .res_valid(res_valid), .res_data(res_data),
    .busy(busy), .done(done), .res_last(res_last), .res_err(res_err)
  );

  typedef struct {
    int         n;
    logic [1:0] mode;
    logic [2:0] rnd;
    bit         echo0;
    int         exp_xfer;
    int         exp_sub0;
    int         exp_sub1;
    int         exp_lat;
  } vec_t;

  logic [DATA_W-1:0] mm [LANES][2][DEPTH];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic load(input int l, input int s, input int a, input logic [DATA_W-1:0] d);
    ld_valid  = 1'b1;
    ld_lane   = LW'(l);
    ld_stream = s[0];
    ld_addr   = AW'(a);
    ld_data   = d;
    @(posedge clk); #1;
    ld_valid  = 1'b0;
    mm[l][s][a] = d;
  endtask

  // Plays one run; the model counts issued/returned operands per lane and
  // predicts valid, operands and op_sub from those counts alone.
  task automatic play(input vec_t v, input bit rs, input logic [3:0] smask, input int scyc);
    int nc, cyc, sub0, sub1;
    int iss [LANES];
    int res [LANES];
    int xf  [LANES];
    logic [3:0] expv, rdy, rv, pfire, dvld;
    logic [DATA_W-1:0] last [LANES];
    logic [DATA_W-1:0] ab   [LANES];
    logic [DATA_W-1:0] pab  [LANES];
    logic [DATA_W-1:0] rd   [LANES];
    logic [LANES*DATA_W-1:0] rdp;
    logic es;
    nc = (v.n > DEPTH) ? DEPTH : v.n;
    for (int l = 0; l < LANES; l++) begin
      iss[l] = 0; res[l] = 0; xf[l] = 0; last[l] = '0; pab[l] = '0;
    end
    pfire = '0; sub0 = -1; sub1 = -1;
    num_ops = 7'(v.n); op_mode = v.mode; rnd_mode = v.rnd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 1000) begin
      for (int l = 0; l < LANES; l++) expv[l] = (iss[l] < nc);
      chk("op_valid", 64'(op_valid), 64'(expv));
      chk("busy", 64'(busy), 64'(1));
      chk("op_rnd", 64'(op_rnd), 64'(v.rnd));
      for (int l = 0; l < LANES; l++) begin
        if (expv[l]) begin
          es = (v.mode == 2'b01) || (v.mode == 2'b10 && (iss[l] % 2) == 1);
          chk("op_a", 64'(op_a[l*DATA_W +: DATA_W]), 64'(mm[l][0][iss[l]]));
          chk("op_b", 64'(op_b[l*DATA_W +: DATA_W]), 64'(mm[l][1][iss[l]]));
          chk("op_sub", 64'(op_sub[l]), 64'(es));
        end
        ab[l] = op_a[l*DATA_W +: DATA_W] ^ op_b[l*DATA_W +: DATA_W];
      end
      if (scyc > 5 && cyc == 5) chk("stall_order", 64'(op_valid), 64'(smask));
      if (rs) begin
        rdy = 4'($urandom);
        for (int l = 0; l < LANES; l++) begin
          rv[l] = (iss[l] > res[l]) && ($urandom % 2 == 1);
          rd[l] = $urandom;
        end
        ld_valid = ($urandom % 4 == 0);
        ld_lane = LW'($urandom); ld_stream = 1'($urandom);
        ld_addr = AW'($urandom); ld_data = $urandom;
        start = ($urandom % 8 == 0);
        num_ops = 7'($urandom_range(1, 70));
      end else begin
        rdy = (cyc < scyc) ? ~smask : 4'hF;
        if (v.echo0) begin
          rv = expv & rdy;
          for (int l = 0; l < LANES; l++) rd[l] = ab[l];
        end else begin
          rv = pfire;
          for (int l = 0; l < LANES; l++) rd[l] = pab[l];
        end
      end
      pfire = expv & rdy;
      for (int l = 0; l < LANES; l++) begin
        pab[l] = ab[l];
        rdp[l*DATA_W +: DATA_W] = rd[l];
      end
      dvld = op_valid;
      if (dvld[0] && rdy[0]) begin
        if (xf[0] == 0) sub0 = int'(op_sub[0]);
        else if (xf[0] == 1) sub1 = int'(op_sub[0]);
      end
      op_ready = rdy; res_valid = rv; res_data = rdp;
      @(posedge clk); #1;
      for (int l = 0; l < LANES; l++) begin
        if (expv[l] && rdy[l]) iss[l]++;
        if (dvld[l] && rdy[l]) xf[l]++;
        if (rv[l]) begin res[l]++; last[l] = rd[l]; end
      end
      cyc++;
    end
    op_ready = '0; res_valid = '0; ld_valid = 1'b0; start = 1'b0;
    chk("done", 64'(done), 64'(1));
    chk("busy_end", 64'(busy), 64'(0));
    chk("op_valid_end", 64'(op_valid), 64'(0));
    chk("res_err_end", 64'(res_err), 64'(0));
    if (v.exp_lat >= 0) chk("latency", 64'(cyc), 64'(v.exp_lat));
    for (int l = 0; l < LANES; l++) begin
      chk("xfer_count", 64'(xf[l]), 64'(v.exp_xfer));
      if (nc > 0) chk("res_last", 64'(res_last[l*DATA_W +: DATA_W]), 64'(last[l]));
    end
    if (v.exp_sub0 >= 0) chk("sub_first", 64'(sub0), 64'(v.exp_sub0));
    if (v.exp_sub1 >= 0) chk("sub_second", 64'(sub1), 64'(v.exp_sub1));
  endtask

  vec_t tbl [8];
  vec_t vr;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_poweron = 1'b1;
    ld_valid = 1'b0; ld_lane = '0; ld_stream = 1'b0; ld_addr = '0; ld_data = '0;
    start = 1'b0; num_ops = '0; op_mode = '0; rnd_mode = '0;
    op_ready = '0; res_valid = '0; res_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_op_valid", 64'(op_valid), 64'(0));
    chk("rst_res_err", 64'(res_err), 64'(0));
    chk("rst_op_rnd", 64'(op_rnd), 64'(0));
    chk("rst_res_last", res_last[63:0], 64'(0));
    chk("rst_op_a", op_a[63:0], 64'(0));
    reset_poweron = 1'b0;
    @(posedge clk); #1;

    for (int l = 0; l < LANES; l++)
      for (int s = 0; s < 2; s++)
        for (int a = 0; a < DEPTH; a++)
          load(l, s, a, $urandom);
    load(0, 0, 0, 32'h3F80_0000);
    load(0, 0, 1, 32'h4020_0000);
    load(0, 1, 0, 32'h4040_0000);
    load(0, 1, 1, 32'h3F00_0000);

    tbl[0] = '{2,  2'b10, 3'd1, 1'b0, 2,  0,  1,  4};
    tbl[1] = '{3,  2'b00, 3'd0, 1'b0, 3,  0,  0,  5};
    tbl[2] = '{3,  2'b01, 3'd7, 1'b0, 3,  1,  1,  5};
    tbl[3] = '{4,  2'b11, 3'd4, 1'b1, 4,  0,  0,  6};
    tbl[4] = '{1,  2'b10, 3'd2, 1'b1, 1,  0,  -1, 3};
    tbl[5] = '{0,  2'b01, 3'd3, 1'b0, 0,  -1, -1, 0};
    tbl[6] = '{69, 2'b10, 3'd5, 1'b0, 64, 0,  1,  66};
    tbl[7] = '{64, 2'b01, 3'd6, 1'b1, 64, 1,  1,  66};
    for (int i = 0; i < 8; i++) begin
      play(tbl[i], 1'b0, 4'h0, 0);
      if (i == 0) begin
        // Surplus result on lane 1 after all its results are in.
        res_valid = 4'b0010; res_data = {LANES{32'hDEAD_BEEF}};
        @(posedge clk); #1;
        res_valid = '0;
        chk("extra_res_err", 64'(res_err), 64'(1));
        chk("extra_res_last", 64'(res_last[DATA_W +: DATA_W]), 64'(mm[1][0][1] ^ mm[1][1][1]));
        chk("extra_done", 64'(done), 64'(1));
      end
    end

    // Lane 2 stalled for ten cycles.
    vr = '{3, 2'b00, 3'd0, 1'b0, 3, 0, 0, 15};
    play(vr, 1'b0, 4'b0100, 10);

    // Abort on the third RUN cycle, then replay.
    num_ops = 7'd4; op_mode = 2'b00; rnd_mode = 3'd6; start = 1'b1; op_ready = 4'hF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("abort_pre_valid", 64'(op_valid), 64'(4'hF));
    #2;
    reset_poweron = 1'b1;
    #1;
    chk("abort_op_valid", 64'(op_valid), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_op_a", op_a[63:0], 64'(0));
    chk("abort_op_b", op_b[63:0], 64'(0));
    chk("abort_op_sub", 64'(op_sub), 64'(0));
    chk("abort_op_rnd", 64'(op_rnd), 64'(0));
    chk("abort_res_last", res_last[63:0], 64'(0));
    @(posedge clk); #1;
    chk("abort_held_valid", 64'(op_valid), 64'(0));
    reset_poweron = 1'b0;
    op_ready = '0;
    @(posedge clk); #1;
    vr = '{4, 2'b00, 3'd6, 1'b0, 4, 0, 0, 6};
    play(vr, 1'b0, 4'h0, 0);

    for (int k = 0; k < 6; k++) begin
      load(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
           int'($urandom_range(0, DEPTH-1)), $urandom);
      vr.n = int'($urandom_range(0, 70));
      vr.mode = 2'($urandom); vr.rnd = 3'($urandom); vr.echo0 = 1'b0;
      vr.exp_xfer = (vr.n > DEPTH) ? DEPTH : vr.n;
      vr.exp_sub0 = -1; vr.exp_sub1 = -1; vr.exp_lat = -1;
      play(vr, 1'b1, 4'h0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/strm_operand_player.md
STRM_OPERAND_PLAYER -- requirements
Module: strm_operand_player

Interface
REQ-001 Parameter LANES, default 4, number of independent operand lanes.
REQ-002 Parameter DATA_W, default 32, operand and result width (IEEE-754 single).
REQ-003 Parameter DEPTH, default 64, operand entries per stream per lane; AW = clog2(DEPTH).
REQ-004 Clock and reset SHALL be one clock and an asynchronous, active-high reset: clk input 1, reset_poweron input 1.
REQ-005 ld_valid input 1; ld_lane input clog2(LANES); ld_stream input 1 (0=A, 1=B); ld_addr input AW; ld_data input DATA_W. Together these form the operand memory write port.
REQ-006 start input 1: launch playback. num_ops input AW+1: operand pairs per lane. op_mode input 2: 00=add, 01=sub, 10=alternate starting add, 11=add. rnd_mode input 3: rounding mode.
REQ-007 op_valid output LANES; op_a output LANES*DATA_W; op_b output LANES*DATA_W; op_sub output LANES; op_rnd output 3; op_ready input LANES.
REQ-008 res_valid input LANES; res_data input LANES*DATA_W.
REQ-009 busy output 1; done output 1; res_last output LANES*DATA_W; res_err output 1.

Function
REQ-010 The FSM SHALL have four states: IDLE, RUN, DRAIN, DONE.
REQ-011 In IDLE or DONE, a cycle with ld_valid high SHALL write ld_data to mem[ld_lane][ld_stream][ld_addr]; ld_valid SHALL be ignored in RUN and DRAIN.
REQ-012 In IDLE or DONE, start with num_ops!=0 SHALL latch num_ops (clamped to DEPTH), op_mode and rnd_mode, clear all lane pointers, result counters and res_err, and enter RUN the next cycle.
REQ-013 start with num_ops==0 SHALL go directly to DONE without asserting any op_valid.
REQ-014 In RUN, lane i SHALL assert op_valid[i] while issue_cnt[i] < latched num_ops, presenting mem[i][A][issue_cnt[i]] and mem[i][B][issue_cnt[i]] combinationally from the pointer.
REQ-015 A transfer on lane i SHALL occur only when op_valid[i] and op_ready[i] are both high; issue_cnt[i] SHALL increment by 1 on that cycle.
REQ-016 op_a, op_b and op_sub SHALL hold stable while op_valid is high and op_ready is low.
REQ-017 op_sub[i] SHALL be 0 for mode add, 1 for mode sub, and issue_cnt[i][0] for mode alternate; op_rnd SHALL equal the latched rnd_mode.
REQ-018 Lanes SHALL progress independently; a stalled lane SHALL NOT block the other lanes.
REQ-019 RUN SHALL go to DRAIN on the cycle after every lane's issue_cnt equals num_ops.
REQ-020 In any state other than IDLE, res_valid[i] SHALL load res_last[i] with res_data[i] and increment res_cnt[i], provided res_cnt[i] < issue_cnt[i].
REQ-021 res_valid[i] with res_cnt[i] >= issue_cnt[i] SHALL set sticky res_err and SHALL NOT update res_last[i] or res_cnt[i].
REQ-022 A result arriving in the same cycle as its issuing transfer SHALL count as valid, because issue_cnt is compared after the increment.
REQ-023 DRAIN SHALL go to DONE when res_cnt[i]==num_ops for all lanes.
REQ-024 done SHALL be high only in DONE and SHALL be held until the next start. busy SHALL be high in RUN and DRAIN.
REQ-025 start SHALL be ignored in RUN and DRAIN.
REQ-026 Counters SHALL be AW+1 bits wide and SHALL NOT wrap, because num_ops is clamped to DEPTH.

Reset
REQ-027 Assertion of reset_poweron SHALL immediately force: state IDLE; op_valid, op_sub, busy, done, res_err = 0; op_a, op_b, res_last = 0; op_rnd = 0; all counters = 0.
REQ-028 Reset asserted mid-RUN or mid-DRAIN SHALL abort playback with no further transfers.
REQ-029 Operand memory contents SHALL NOT be cleared by reset.

Verification
REQ-030 Load lane0 A={1.0,2.5}, B={3.0,0.5}; num_ops=2, mode=10, op_ready=1, echo results after 1 cycle -> two transfers with op_sub 0 then 1; done 4 cycles after start; res_err=0.
REQ-031 4 lanes, num_ops=3, op_ready[2] held low 10 cycles -> lanes 0, 1 and 3 finish issuing first; lane 2 op_a stays stable while stalled; DRAIN is entered only after lane 2 issues 3.
REQ-032 num_ops=0 -> done the next cycle; op_valid never asserted.
REQ-033 Extra res_valid[1] after lane 1 results are complete -> res_err=1; res_last[1] unchanged; done still asserted.
REQ-034 Reset pulse on the third RUN cycle -> all outputs 0 immediately; a subsequent start with unchanged memory replays the same operands.
REQ-035 num_ops=DEPTH+5 -> exactly DEPTH transfers per lane; counters reach DEPTH without wrap.
